// File: rtl/com_tx_gen.sv
// Bag transmitter: HEAD, TYPE, [LEN, payload], check byte on com_txd, one byte per clk.
// Define COM_TX_CRC8_EN to replace the XOR check byte with CRC-8 (poly 0x07).
module com_tx_gen #(
  parameter logic [7:0] HEAD      = 8'hA5,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter int         NPARAM    = 3,
  parameter int         DLEN_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fs,
  output logic                  fd,
  input  logic [3:0]            btype,
  input  logic [4*NPARAM-1:0]   param,
  input  logic [DLEN_W-1:0]     dlen,
  input  logic [7:0]            din,
  output logic                  din_rd,
  output logic [7:0]            com_txd,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_SUM  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]          r_state;
  logic [3:0]          r_btype;
  logic [4*NPARAM-1:0] r_param;
  logic [DLEN_W-1:0]   r_dlen;
  logic [DLEN_W-1:0]   r_dcnt;
  logic [DLEN_W-1:0]   r_rd_left;
  logic [7:0]          r_chk;
  logic [7:0]          r_txd;

  logic [3:0]          w_bdata;
  logic [7:0]          w_type_byte;
  logic [7:0]          w_len_byte;
  logic                w_is_data;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
`ifdef COM_TX_CRC8_EN
    c = acc ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`else
    c = acc ^ b;
`endif
    return c;
  endfunction

  // Codes 0101..1010 select nibble 0..5; nibbles beyond NPARAM read as zero.
  always_comb begin
    w_bdata = 4'h0;
    for (int i = 0; i < NPARAM; i++) begin
      if (r_btype == 4'(i + 5)) w_bdata = r_param[4*i +: 4];
    end
  end

  assign w_type_byte = {r_btype, w_bdata};
  assign w_len_byte  = 8'(r_dlen);
  assign w_is_data   = (r_btype == 4'b1101) || (r_btype == 4'b1110);

  assign com_txd = r_txd;
  assign fd      = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign din_rd  = (r_rd_left != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_btype   <= 4'h0;
      r_param   <= '0;
      r_dlen    <= '0;
      r_dcnt    <= '0;
      r_rd_left <= '0;
      r_chk     <= 8'h00;
      r_txd     <= IDLE_BYTE;
    end else begin
      if (r_rd_left != '0) r_rd_left <= r_rd_left - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (fs) begin
            r_btype <= btype;
            r_param <= param;
            r_dlen  <= dlen;
            r_chk   <= 8'h00;
            if (btype == 4'b0000) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_HEAD;
              r_txd   <= HEAD;
            end
          end
        end
        S_HEAD: begin
          r_state   <= S_TYPE;
          r_txd     <= w_type_byte;
          r_chk     <= chk_step(r_chk, w_type_byte);
          // Reads start now so the first payload byte lands right after LEN.
          r_rd_left <= w_is_data ? r_dlen : '0;
        end
        S_TYPE: begin
          if (w_is_data) begin
            r_state <= S_LEN;
            r_txd   <= w_len_byte;
            r_chk   <= chk_step(r_chk, w_len_byte);
          end else begin
            r_state <= S_SUM;
            r_txd   <= r_chk;
          end
        end
        S_LEN: begin
          if (r_dlen == '0) begin
            r_state <= S_SUM;
            r_txd   <= r_chk;
          end else begin
            r_state <= S_DATA;
            r_txd   <= din;
            r_chk   <= chk_step(r_chk, din);
            r_dcnt  <= r_dlen - 1'b1;
          end
        end
        S_DATA: begin
          if (r_dcnt == '0) begin
            r_state <= S_SUM;
            r_txd   <= r_chk;
          end else begin
            r_txd  <= din;
            r_chk  <= chk_step(r_chk, din);
            r_dcnt <= r_dcnt - 1'b1;
          end
        end
        S_SUM: begin
          r_state <= S_DONE;
          r_txd   <= IDLE_BYTE;
        end
        S_DONE: begin
          if (!fs) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= IDLE_BYTE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_tx_gen.sv
// Directed and randomized frames checked against a byte-list reference model.
module tb_com_tx_gen;
  localparam int NPARAM = 3;
  localparam int DLEN_W = 8;
  localparam int PW     = 4 * NPARAM;

  logic              clk = 1'b0;
  logic              rst;
  logic              fs;
  logic              fd;
  logic [3:0]        btype;
  logic [PW-1:0]     param;
  logic [DLEN_W-1:0] dlen;
  logic [7:0]        din;
  logic              din_rd;
  logic [7:0]        com_txd;
  logic              busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pidx;
  logic       rd_before;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] cap_q[$];

  always #5 clk = ~clk;

  com_tx_gen #(.HEAD(8'hA5), .IDLE_BYTE(8'h00), .NPARAM(NPARAM), .DLEN_W(DLEN_W)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .btype(btype), .param(param), .dlen(dlen),
    .din(din), .din_rd(din_rd), .com_txd(com_txd), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a read strobe seen before the edge presents the next FIFO byte after it.
  task automatic tick();
    rd_before = din_rd;
    @(posedge clk);
    #1;
    if (rd_before) begin
      din = (pidx < pay_q.size()) ? pay_q[pidx] : 8'hEE;
      pidx++;
    end
  endtask

  function automatic logic [3:0] ref_bdata(input logic [3:0] bt, input logic [PW-1:0] prm);
    int idx;
    if (bt >= 4'd5 && bt <= 4'd10) begin
      idx = int'(bt) - 5;
      if (idx < NPARAM) return prm[4*idx +: 4];
    end
    return 4'h0;
  endfunction

  // Check over exp_q[1..]: XOR fold, or CRC-8 as polynomial long division by x^8+x^2+x+1.
  function automatic logic [7:0] ref_check();
    logic [7:0] x;
    logic [8:0] rem;
    x   = 8'h00;
    rem = 9'h000;
    for (int i = 1; i < exp_q.size(); i++) x ^= exp_q[i];
    for (int i = 1; i < exp_q.size() + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], (i < exp_q.size()) ? exp_q[i][b] : 1'b0};
        if (rem[8]) rem ^= 9'h107;
      end
    end
`ifdef COM_TX_CRC8_EN
    return rem[7:0];
`else
    if (rem[8]) return 8'hFF;
    return x;
`endif
  endfunction

  task automatic build_expected(input logic [3:0] bt, input logic [PW-1:0] prm, input logic [7:0] len);
    logic [7:0] ck;
    exp_q.delete();
    if (bt == 4'b0000) return;
    exp_q.push_back(8'hA5);
    exp_q.push_back({bt, ref_bdata(bt, prm)});
    if (bt == 4'b1101 || bt == 4'b1110) begin
      exp_q.push_back(len);
      for (int i = 0; i < int'(len); i++) exp_q.push_back(pay_q[i]);
    end
    ck = ref_check();
    exp_q.push_back(ck);
  endtask

  task automatic fill_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic run_frame(input string tag, input logic [3:0] bt, input logic [PW-1:0] prm,
                           input logic [7:0] len, input bit drop_fs, input bit scramble);
    bit is_data;
    is_data = (bt == 4'b1101) || (bt == 4'b1110);
    pidx = 0;
    build_expected(bt, prm, len);
    cap_q.delete();
    btype = bt; param = prm; dlen = len; fs = 1'b1;
    tick();
    if (scramble) begin
      btype = 4'($urandom); param = PW'($urandom); dlen = 8'($urandom);
    end
    if (drop_fs) fs = 1'b0;
    if (bt == 4'b0000) begin
      check({tag, "/init_txd"}, com_txd, 8'h00);
      check({tag, "/init_busy"}, busy, 1'b0);
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        cap_q.push_back(com_txd);
        check({tag, "/byte"}, com_txd, exp_q[k]);
        check({tag, "/busy"}, busy, 1'b1);
        check({tag, "/din_rd"}, din_rd, is_data && k >= 1 && k < 1 + int'(len));
        tick();
      end
    end
    check({tag, "/fd_done"}, fd, 1'b1);
    check({tag, "/busy_done"}, busy, 1'b0);
    check({tag, "/txd_done"}, com_txd, 8'h00);
    check({tag, "/reads"}, pidx, is_data ? int'(len) : 0);
    if (!drop_fs) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        check({tag, "/hold_fd"}, fd, 1'b1);
        check({tag, "/hold_busy"}, busy, 1'b0);
      end
    end
    fs = 1'b0;
    tick();
    check({tag, "/fd_clear"}, fd, 1'b0);
  endtask

  initial begin
    rst = 1'b0; fs = 1'b0; btype = 4'h0; param = '0; dlen = '0; din = 8'h00; pidx = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/txd", com_txd, 8'h00);
    check("rst/fd", fd, 1'b0);
    check("rst/din_rd", din_rd, 1'b0);
    check("rst/busy", busy, 1'b0);
    rst = 1'b1;
    tick();

    fill_payload(0);
    run_frame("ack", 4'b0001, 12'h000, 8'd0, 1'b0, 1'b0);
    check("ack/len", cap_q.size(), 3);
`ifdef COM_TX_CRC8_EN
    check("ack/crc", cap_q[2], 8'h70);
`else
    check("ack/sum", cap_q[2], 8'h10);
`endif
    run_frame("didx0", 4'b0101, 12'hA35, 8'd0, 1'b0, 1'b1);
    check("didx0/type", cap_q[1], 8'h55);
    run_frame("didx2", 4'b0111, 12'hA35, 8'd0, 1'b1, 1'b0);
    check("didx2/type", cap_q[1], 8'h7A);
    run_frame("didx3", 4'b1000, 12'hA35, 8'd0, 1'b0, 1'b0);
    check("didx3/type", cap_q[1], 8'h80);

    pay_q.delete();
    pay_q.push_back(8'h01); pay_q.push_back(8'h02); pay_q.push_back(8'h04);
    run_frame("data3", 4'b1101, 12'h000, 8'd3, 1'b0, 1'b1);
    check("data3/len", cap_q.size(), 7);
`ifndef COM_TX_CRC8_EN
    check("data3/sum", cap_q[6], 8'hD4);
`endif
    fill_payload(0);
    run_frame("data0", 4'b1101, 12'h000, 8'd0, 1'b0, 1'b0);
    check("data0/len", cap_q.size(), 4);
    run_frame("init", 4'b0000, 12'h000, 8'd0, 1'b0, 1'b0);

    // Reset in the middle of a 5-byte payload.
    fill_payload(5);
    pidx = 0;
    btype = 4'b1101; param = '0; dlen = 8'd5; fs = 1'b1;
    repeat (4) tick();
    check("midrst/in_data", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst/txd", com_txd, 8'h00);
    check("midrst/fd", fd, 1'b0);
    check("midrst/din_rd", din_rd, 1'b0);
    check("midrst/busy", busy, 1'b0);
    fs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("midrst/idle_busy", busy, 1'b0);
    fill_payload(5);
    run_frame("after_rst", 4'b1110, 12'h000, 8'd5, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [3:0] bt;
      logic [7:0] len;
      bt  = 4'($urandom);
      if (n % 3 == 0) bt = ($urandom_range(0, 1) == 0) ? 4'b1101 : 4'b1110;
      len = 8'($urandom_range(0, 10));
      fill_payload(int'(len));
      run_frame("rand", bt, PW'($urandom), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/com_tx_gen.md
Name: com_tx_gen

Overview:
- Parametrised successor to the single-nibble bag transmitter.
- Serialises one bag per fs/fd handshake into a byte stream on com_txd, one byte per clk. The stream feeds the com_txf line encoder.
- Frame layout: sync header, {btype, bdata} type byte, optional length byte plus variable-length payload for DATA bags, then trailing check byte.
- Generalises the fixed didx/freq/ddidx inputs to NPARAM parameter nibbles.

Parameters:
HEAD, 8'hA5, sync byte opening every frame
IDLE_BYTE, 8'h00, value on com_txd when no frame is in flight
NPARAM, 3, number of 4-bit parameter nibbles (1..6)
DLEN_W, 8, width of payload length (max 8; length byte carries it zero-extended)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
fs  in  1  frame start request, level; held by requester until fd
fd  out  1  frame done; high until fs observed low
btype  in  4  bag type; latched when fs accepted
param  in  4*NPARAM  parameter nibbles; nibble i = param[4i+3:4i]; latched with btype
dlen  in  DLEN_W  payload byte count for DATA0/DATA1 bags; latched with btype
din  in  8  payload byte; valid the cycle after din_rd
din_rd  out  1  payload read strobe, one per byte (sync-FIFO read, 1-cycle latency)
com_txd  out  8  registered transmit byte stream
busy  out  1  high while frame bytes are on com_txd

Behaviour:
- Reset (rst low, async):
  - com_txd=IDLE_BYTE; fd=0; din_rd=0; busy=0; state IDLE; check accumulator cleared.
  - Applies mid-frame too; the frame is abandoned with no trailing bytes.
- State machine: IDLE, HEAD, TYPE, LEN, DATA, SUM, DONE.
- IDLE:
  - fs sampled high at edge e0 latches btype/param/dlen and enters HEAD.
  - Exception: btype 4'b0000 (INIT) goes straight to DONE and sends nothing.
- Per-state output:
  - HEAD outputs HEAD.
  - TYPE outputs {btype, bdata}.
  - LEN outputs dlen zero-extended.
  - DATA outputs din bytes.
  - SUM outputs the check byte.
  - Each state is one cycle except DATA, which lasts dlen cycles.
- bdata mapping:
  - 0101→nibble0, 0110→nibble1, 0111→nibble2, 1000→nibble3, 1001→nibble4, 1010→nibble5.
  - Yields 0 if that nibble index ≥ NPARAM. All other codes: bdata=0.
- Bag classes:
  - DATA bags (1101, 1110): HEAD, TYPE, LEN, DATA×dlen, SUM.
  - All other non-INIT codes are control bags: HEAD, TYPE, SUM (3 bytes).
- Timing:
  - HEAD appears on com_txd the cycle after e0.
  - busy is high exactly while HEAD..SUM bytes are on com_txd.
- din_rd:
  - Asserted for dlen consecutive cycles, starting the cycle TYPE is on com_txd.
  - din is registered onto com_txd at the following edges, so the payload is gapless after LEN.
  - dlen=0: no din_rd, LEN=0x00, SUM follows LEN directly.
- Check byte: XOR of all bytes after HEAD (TYPE, LEN, payload).
- DONE:
  - fd=1 and com_txd=IDLE_BYTE from the cycle after SUM.
  - fd stays high until fs is sampled low, then returns to IDLE with fd=0 next cycle.
- Request sequencing:
  - fs dropping mid-frame does not abort; the frame completes and DONE exits immediately on the low fs.
  - A new request requires fs to go low then high; fs held high past DONE does not retrigger.
  - Changes to btype/param/dlen after acceptance have no effect on the current frame.

Optional Feature:
- COM_TX_CRC8_EN defined: the SUM byte is CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over the same bytes the XOR would cover.
- Undefined: XOR check byte as above.
- Frame length and timing are identical either way.

Test Plan:
- Reset low mid-DATA with dlen=5 → com_txd=0x00, fd=0, din_rd=0, busy=0 immediately; after release, a new fs sends a complete frame.
- btype=ACK 0001, fs held → com_txd A5,10,10 then 00, fd high the cycle after 0x10 SUM; fs low → fd low next cycle.
- btype=DIDX 0101, param=12'hA35 → A5,55,55; btype=0111 → A5,7A,7A; btype=1000 with NPARAM=3 → A5,80,80.
- btype=DATA0 1101, dlen=3, din 01,02,04 → A5,D0,03,01,02,04,D4; din_rd high 3 cycles starting at the D0 cycle; dlen=0 → A5,D0,00,D0.
- btype=INIT 0000 → no bytes, busy stays 0, fd high the cycle after acceptance; fs kept high after a completed frame → no second frame.
- COM_TX_CRC8_EN, btype=ACK → A5,10,70.
